// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   Multi-channel front-panel key conditioner. Each channel is fully
//   independent and goes through these stages:
//     raw pin -> 2-flop synchroniser -> stability-window debouncer -> level
//     -> press/release edge pulses -> hold FSM (long press, auto-repeat).
//
// Ports
//   clk           : system clock
//   reset_n       : asynchronous active-low reset
//   keyin         : [CH] raw asynchronous key pins
//   key_level     : [CH] debounced level, same polarity as keyin
//   press_pulse   : [CH] 1-cycle pulse when key_level becomes ACTIVE_LEVEL
//   release_pulse : [CH] 1-cycle pulse when key_level leaves ACTIVE_LEVEL
//   long_pulse    : [CH] 1-cycle pulse LONG_CYCLES after press_pulse
//   repeat_pulse  : [CH] 1-cycle pulse every REPEAT_CYCLES after long_pulse
//                   while the key is still held (REPEAT_CYCLES == 0: never)
//
// All outputs are registered.
module key_debounce_multi #(
   parameter int unsigned CH            = 4,
   parameter int unsigned STABLE_CYCLES = 16'd8,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned LONG_CYCLES   = 24'd20,
   parameter int unsigned REPEAT_CYCLES = 24'd5,
   parameter int unsigned HOLD_W        = 24,
   parameter logic        ACTIVE_LEVEL  = 1'b0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [CH-1:0] keyin,
   output logic [CH-1:0] key_level,
   output logic [CH-1:0] press_pulse,
   output logic [CH-1:0] release_pulse,
   output logic [CH-1:0] long_pulse,
   output logic [CH-1:0] repeat_pulse
);

   // Terminal counts, pre-cast to the counter widths.
   localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
   localparam logic              RELEASED    = ~ACTIVE_LEVEL;

   typedef enum logic [1:0] {
      REL = 2'd0,   // key released (or press not yet seen)
      PRS = 2'd1,   // pressed, counting towards long press
      HLD = 2'd2    // long press reached, auto-repeat phase
   } hold_state_t;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic              s1;
      logic              s2;
      logic [CNT_W-1:0]  cnt;
      logic              lvl;
      logic              lvl_d;
      logic              press_q;
      logic              release_q;
      logic              long_q;
      logic              repeat_q;
      logic              press_evt;
      logic              release_evt;
      hold_state_t       state;
      hold_state_t       state_nx;
      logic [HOLD_W-1:0] hold_cnt;
      logic [HOLD_W-1:0] hold_cnt_nx;
      logic              long_nx;
      logic              repeat_nx;

      // Debounced level changed on the previous edge. These are the
      // conditions that register into press_pulse / release_pulse, and the
      // hold FSM reacts to them on the same edge so that its counting is
      // aligned with the visible pulses.
      assign press_evt   = (lvl == ACTIVE_LEVEL) && (lvl_d == RELEASED);
      assign release_evt = (lvl == RELEASED) && (lvl_d == ACTIVE_LEVEL);

      // Synchroniser, debouncer and edge pulses.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s1        <= RELEASED;
            s2        <= RELEASED;
            cnt       <= '0;
            lvl       <= RELEASED;
            lvl_d     <= RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            s1        <= keyin[i];
            s2        <= s1;
            lvl_d     <= lvl;
            press_q   <= press_evt;
            release_q <= release_evt;
            // The window restarts whenever s2 agrees with the current level,
            // so a bounce anywhere inside the window throws the count away.
            if (s2 == lvl) begin
               cnt <= '0;
            end else if (cnt < STABLE_LAST) begin
               cnt <= cnt + CNT_W'(1);
            end else begin
               lvl <= s2;
               cnt <= '0;
            end
         end
      end

      // Hold FSM: state register.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state    <= REL;
            hold_cnt <= '0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
         end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            long_q   <= long_nx;
            repeat_q <= repeat_nx;
         end
      end

      // Hold FSM: next state. A release overrides everything, which also
      // drops any long/repeat pulse that would otherwise fire on that edge.
      always_comb begin
         state_nx    = state;
         hold_cnt_nx = hold_cnt;
         long_nx     = 1'b0;
         repeat_nx   = 1'b0;
         if (release_evt) begin
            state_nx    = REL;
            hold_cnt_nx = '0;
         end else begin
            case (state)
               REL: begin
                  if (press_evt) begin
                     state_nx    = PRS;
                     hold_cnt_nx = '0;
                  end
               end
               PRS: begin
                  if (hold_cnt == LONG_LAST) begin
                     long_nx     = 1'b1;
                     state_nx    = HLD;
                     hold_cnt_nx = '0;
                  end else begin
                     hold_cnt_nx = hold_cnt + HOLD_W'(1);
                  end
               end
               HLD: begin
                  // With repeat disabled the counter simply stays frozen.
                  if (REPEAT_CYCLES != 0) begin
                     if (hold_cnt == REPEAT_LAST) begin
                        repeat_nx   = 1'b1;
                        hold_cnt_nx = '0;
                     end else begin
                        hold_cnt_nx = hold_cnt + HOLD_W'(1);
                     end
                  end
               end
               default: begin
                  state_nx    = REL;
                  hold_cnt_nx = '0;
               end
            endcase
         end
      end

      assign key_level[i]     = lvl;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
      assign long_pulse[i]    = long_q;
      assign repeat_pulse[i]  = repeat_q;
   end

endmodule
